// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// Stats width is also used when PIPE_STAGE_STATS_EN is defined.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } PipeState_t;

    localparam int unsigned STATS_W = 32;
    localparam logic [STATS_W-1:0] STATS_INC = STATS_W'(1);

endpackage : pipe_pkg

// File: rtl/pipe_stage_stats.sv
// Bubble and backpressure cycle counters for one pipeline stage.
// Built only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_stats
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               out_valid,
    input  logic               out_ready,
    output logic [STATS_W-1:0] stat_bubbles,
    output logic [STATS_W-1:0] stat_backpressure
);

    logic [STATS_W-1:0] r_bubbles;
    logic [STATS_W-1:0] r_backpressure;
    logic               w_bubble;
    logic               w_stall;

    // A frozen stage is not a bubble, only an idle unfrozen one is.
    assign w_bubble = !out_valid && !hold;
    assign w_stall  = out_valid && !out_ready;

    // Counters wrap naturally; flush is deliberately not an input here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubbles      <= '0;
            r_backpressure <= '0;
        end else begin
            if (w_bubble) r_bubbles      <= r_bubbles + STATS_INC;
            if (w_stall)  r_backpressure <= r_backpressure + STATS_INC;
        end
    end

    assign stat_bubbles      = r_bubbles;
    assign stat_backpressure = r_backpressure;

endmodule : pipe_stage_stats

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: main slot + skid slot, hazard hold, masked flush.
// Define PIPE_STAGE_STATS_EN to add stat_bubbles / stat_backpressure ports.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] FLUSH_MASK  = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               hold,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_bubbles,
    output logic [STATS_W-1:0] stat_backpressure
`endif
);

    PipeState_t       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_emit;
    logic [WIDTH-1:0] w_main_flushed;
    logic [WIDTH-1:0] w_skid_flushed;

    // in_ready depends only on hold and registered state, never on out_ready.
    assign in_ready  = !hold && (r_state != TWO);
    assign out_valid = !hold && (r_state != EMPTY);
    assign out_data  = r_main;

    assign w_accept = in_valid && in_ready;
    assign w_emit   = out_valid && out_ready;

    assign w_main_flushed = (r_main & ~FLUSH_MASK) | (RESET_VALUE & FLUSH_MASK);
    assign w_skid_flushed = (r_skid & ~FLUSH_MASK) | (RESET_VALUE & FLUSH_MASK);

    // NOTE: state and both data slots use non-blocking assignments so every
    // read in this block sees the pre-edge value (TWO->ONE reads old r_skid).
    // NOTE: the data slots are reset too, because out_data must show
    // RESET_VALUE straight out of reset even though out_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
        end else if (flush) begin
            r_state <= EMPTY;
            r_main  <= w_main_flushed;
            r_skid  <= w_skid_flushed;
        end else begin
            // hold forces w_accept and w_emit low, so nothing below fires.
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= ONE;
                        r_main  <= in_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_emit) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_state <= TWO;
                        r_skid  <= in_data;
                    end else if (w_emit) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_emit) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .clk               (clk),
        .reset             (reset),
        .hold              (hold),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .stat_bubbles      (stat_bubbles),
        .stat_backpressure (stat_backpressure)
    );
`endif

endmodule : pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register. It is the next generation of the fixed D->E enable/flush flop bank.
- Carries one packed payload of WIDTH bits with valid/ready handshake, a 2-entry skid buffer, hazard hold, and a flush that loads a programmable bubble pattern.
- Instantiated between any two core stages (F/D, D/E, E/M, M/W) so backpressure from long-latency units (mul/div, memory) needs no global stall fan-out.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VALUE, '0 (WIDTH bits), payload value after reset and the bubble pattern loaded on flush (e.g. NOP_INSTR for instruction fields).
- FLUSH_MASK, '1 (WIDTH bits), per-bit select. 1 = bit takes RESET_VALUE on flush; 0 = bit keeps its stored value.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held entries (hazard/branch unit).
- hold  in  1  hazard freeze: no transfer on either side this cycle.
- in_valid  in  1  upstream presents payload.
- in_ready  out  1  stage can accept; registered (no comb path from out_ready).
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  downstream payload; registered.

Behaviour:
- Storage: main slot (drives out_*) plus skid slot. State is one of EMPTY, ONE (main full), TWO (main + skid full).
- Handshake signals:
  - in_ready = !hold & (state != TWO); the TWO term is registered.
  - out_valid = !hold & (state != EMPTY).
  - out_data = main slot data, always driven, including when invalid.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready. Both are zero while hold=1.
- Transitions:
  - EMPTY: accept -> ONE, main := in_data.
  - ONE:
    - accept & emit -> ONE, main := in_data.
    - accept & !emit -> TWO, skid := in_data.
    - !accept & emit -> EMPTY.
    - otherwise stay.
  - TWO:
    - emit -> ONE, main := skid.
    - No accept is possible in TWO.
- Latency: 1 cycle in->out when the stage is empty; 100% throughput with out_ready held high; no bubble inserted on a ready deassert/reassert.
- Ordering: strict FIFO. Payloads are never dropped or duplicated.
- Reset (async): state := EMPTY; main and skid := RESET_VALUE; in_ready = 1; out_valid = 0; out_data = RESET_VALUE.
- flush (synchronous, highest priority, dominates hold, in_valid and out_ready):
  - Next state = EMPTY.
  - Main and skid := (data & ~FLUSH_MASK) | (RESET_VALUE & FLUSH_MASK).
  - An in_valid in the flush cycle is discarded.
  - In the flush cycle itself out_valid still reflects the current state; a same-cycle emit counts as delivered.
- hold with in_valid=1: payload is not taken; upstream must keep it stable.
- Reset asserted mid-transfer: all entries lost, outputs at reset values immediately (async).
- hold=1 and flush=0: all state and data frozen.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined:
  - Adds out ports stat_bubbles[31:0] and stat_backpressure[31:0].
  - stat_bubbles counts cycles with out_valid=0 and hold=0.
  - stat_backpressure counts cycles with out_valid=1 and out_ready=0.
  - Both counters wrap at 2^32-1 -> 0, clear on reset, and are unaffected by flush.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum logic [1:0] PipeState_t {EMPTY, ONE, TWO}.
  - Localparam for the stats counter width (32).
- Sub-module pipe_stage_stats holds both counters and is instantiated only under PIPE_STAGE_STATS_EN.
- Payload muxing stays inline in pipe_stage_reg.

Test Plan:
- Reset, WIDTH=32, RESET_VALUE=32'h00000013: after reset out_valid=0, out_data=32'h00000013, in_ready=1.
- Streaming, out_ready=1: in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 on the following three cycles, in_ready never drops.
- Backpressure: send 0xA, 0xB, 0xC with out_ready=0 -> stage holds 0xA (main) and 0xB (skid), in_ready=0 after two accepts, 0xC waits. Then raise out_ready -> 0xA, 0xB, 0xC emitted in order, nothing lost.
- Flush in TWO with FLUSH_MASK=32'h0000_00FF, stored 0x1234_5678: next cycle state EMPTY, main data 0x1234_5613, in_ready=1, the same-cycle in_valid payload never appears.
- hold=1 for 3 cycles in ONE with in_valid=1 and out_ready=1 -> no accept, no emit, out_data stable. hold=0 -> normal flow resumes.
- PIPE_STAGE_STATS_EN: 5 empty cycles then 4 stalled-valid cycles -> stat_bubbles=5, stat_backpressure=4. A preloaded stat_bubbles of 32'hFFFF_FFFF plus one bubble wraps to 0.
